fault_injection_module: RTL and testbench
=========================================

// Module: fault_injection_module
// PURPOSE
//  Gate-level fault-injection wrapper around a 4-input logic cone, used to
//  validate ATPG pattern sets by comparing faulty against fault-free response.
//  Core function: y = (a & b) | (e & ~f). One selectable site can be forced
//  stuck-at-0/1 or given a slow-to-rise/slow-to-fall transition fault.
//  Sits between the pattern source and the response logger; output is registered.
// PARAMETERS
//  RESET_Y   1'b0  value driven on y (and y_golden) during/after reset
// PORTS
//  clk         in   1  single clock, all state on rising edge
//  rst_n       in   1  synchronous active-low reset
//  a           in   1  functional input a
//  b           in   1  functional input b
//  e           in   1  functional input e
//  f           in   1  functional input f
//  fault_en    in   1  1 = apply selected fault, 0 = fault-free operation
//  fault_site  in   3  0=a 1=b 2=e 3=f 4=n1(a&b) 5=n2(e&~f) 6=y_pre 7=none
//  fault_type  in   2  0=SA0 1=SA1 2=slow-to-rise(STR) 3=slow-to-fall(STF)
//  y           out  1  registered (possibly faulty) response
// BEHAVIOUR
//  - Internal nets: n1 = a_f & b_f; n2 = e_f & ~f_f; y_pre = n1_f | n2_f, where
//    x_f is net x after the fault override (only the selected site differs).
//  - Faults propagate: a fault on an input site affects all downstream nets.
//  - SA0/SA1: selected net forced to 0/1 in the same cycle it is selected.
//  - STR: if the selected net's fault-free value is 1 and its registered
//    fault-free value from the previous cycle is 0, net reads 0 this cycle;
//    otherwise net reads its fault-free value. STF: symmetric (reads 1 on 1->0).
//  - Per-site previous-value register holds fault-free value of all 7 nets,
//    updated every cycle regardless of fault_en.
//  - fault_en=0 or fault_site=7: y_pre is the fault-free value.
//  - y <= y_pre on every rising edge: latency 1 cycle from inputs/fault ctrl.
//  - Fault controls are sampled every cycle; changing them mid-stream takes
//    effect on the next edge, no pipeline flush.
//  - Reset (rst_n=0 at edge): y <= RESET_Y, all previous-value regs <= 0.
//    First cycle after reset: a net at 1 counts as rising for STR.
//  - Reset dominates any simultaneous input or fault-control change.
// CONFIGURATION
//  INJ_GOLDEN_OUT_EN defined: adds outputs y_golden (out,1, registered
//  fault-free y, reset RESET_Y) and mismatch (out,1, registered y_pre^golden,
//  reset 0), both with the same 1-cycle latency as y.
//  Not defined: ports and logic absent; y is the only output.
// TESTING
//  1 fault_en=0, a,b,e,f=0,0,1,0 -> y=1 next cycle; 1,0,0,1 -> y=0.
//  2 SA0 on site 4 (n1), inputs 1,1,0,0 -> y=0 (golden 1, mismatch=1 if EN).
//  3 SA1 on site 3 (f), inputs 0,0,1,1 -> y=0; same inputs SA0 on f -> y=1.
//  4 STR on site 0 (a): b=1,e=0,f=1, a 0->1 -> y=0 on first cycle, y=1 next.
//  5 STF on site 6: 1,1,0,0 then 0,0,0,1 -> y stays 1 one cycle, then 0.
//  6 rst_n=0 mid-stream with y=1 -> y=0 next edge; fault_site=7 -> golden.

Source files
------------

// File: rtl/fault_injection_module.sv
// fault_injection_module
//   Fault-injection wrapper around the cone y = (a & b) | (e & ~f).
//   One net can be stuck-at-0/1, slow-to-rise or slow-to-fall.
//   The registered output y has a latency of one cycle.
//   Optional feature macro: INJ_GOLDEN_OUT_EN. It adds the y_golden and mismatch outputs.
module fault_injection_module #(
  parameter logic RESET_Y = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       e,
  input  logic       f,
  input  logic       fault_en,
  input  logic [2:0] fault_site,
  input  logic [1:0] fault_type,
`ifdef INJ_GOLDEN_OUT_EN
  output logic       y_golden,
  output logic       mismatch,
`endif
  output logic       y
);

  typedef enum logic [1:0] {
    FT_SA0 = 2'd0,
    FT_SA1 = 2'd1,
    FT_STR = 2'd2,
    FT_STF = 2'd3
  } fault_type_e;

  // Bit order of the net vectors: {y_pre, n2, n1, f, e, b, a}.
  // This order matches the fault_site encoding 0..6.
  localparam int NET_A  = 0;
  localparam int NET_B  = 1;
  localparam int NET_E  = 2;
  localparam int NET_F  = 3;
  localparam int NET_N1 = 4;
  localparam int NET_N2 = 5;
  localparam int NET_Y  = 6;

  // Compute the value that a selected net reads under the given fault.
  // The transition faults compare against the fault-free value of the last cycle.
  function automatic logic inject(input logic val, input logic prev, input fault_type_e ft);
    logic r;
    r = val;
    case (ft)
      FT_SA0:  r = 1'b0;
      FT_SA1:  r = 1'b1;
      FT_STR:  r = (val && !prev) ? 1'b0 : val;
      FT_STF:  r = (!val && prev) ? 1'b1 : val;
      default: r = val;
    endcase
    return r;
  endfunction

  logic [6:0]  sel_p0;
  logic [6:0]  gold_p0;
  logic [6:0]  flt_p0;
  logic [6:0]  prev_p1;
  fault_type_e ft_p0;

  // The select is one-hot when the fault is enabled.
  // Site 7 shifts out of the 7-bit vector, so it selects no net.
  assign sel_p0 = fault_en ? 7'(8'd1 << fault_site) : 7'd0;
  assign ft_p0  = fault_type_e'(fault_type);

  // Compute the fault-free cone and the faulty cone.
  // The faulty cone uses overridden upstream nets, so a fault propagates downstream.
  always_comb begin
    gold_p0 = '0;
    flt_p0  = '0;

    gold_p0[NET_A]  = a;
    gold_p0[NET_B]  = b;
    gold_p0[NET_E]  = e;
    gold_p0[NET_F]  = f;
    gold_p0[NET_N1] = a & b;
    gold_p0[NET_N2] = e & ~f;
    gold_p0[NET_Y]  = gold_p0[NET_N1] | gold_p0[NET_N2];

    flt_p0[NET_A] = sel_p0[NET_A] ? inject(a, prev_p1[NET_A], ft_p0) : a;
    flt_p0[NET_B] = sel_p0[NET_B] ? inject(b, prev_p1[NET_B], ft_p0) : b;
    flt_p0[NET_E] = sel_p0[NET_E] ? inject(e, prev_p1[NET_E], ft_p0) : e;
    flt_p0[NET_F] = sel_p0[NET_F] ? inject(f, prev_p1[NET_F], ft_p0) : f;

    flt_p0[NET_N1] = flt_p0[NET_A] & flt_p0[NET_B];
    if (sel_p0[NET_N1])
      flt_p0[NET_N1] = inject(flt_p0[NET_N1], prev_p1[NET_N1], ft_p0);

    flt_p0[NET_N2] = flt_p0[NET_E] & ~flt_p0[NET_F];
    if (sel_p0[NET_N2])
      flt_p0[NET_N2] = inject(flt_p0[NET_N2], prev_p1[NET_N2], ft_p0);

    flt_p0[NET_Y] = flt_p0[NET_N1] | flt_p0[NET_N2];
    if (sel_p0[NET_Y])
      flt_p0[NET_Y] = inject(flt_p0[NET_Y], prev_p1[NET_Y], ft_p0);
  end

  // ---- stage p0 -> p1 boundary ----
  // Register the response and the fault-free history.
  // Reset clears the history, so a net at 1 right after reset reads as rising.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y       <= RESET_Y;
      prev_p1 <= '0;
    end else begin
      y       <= flt_p0[NET_Y];
      prev_p1 <= gold_p0;
    end
  end

`ifdef INJ_GOLDEN_OUT_EN
  // Register the fault-free response and the faulty-versus-golden difference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_golden <= RESET_Y;
      mismatch <= 1'b0;
    end else begin
      y_golden <= gold_p0[NET_Y];
      mismatch <= flt_p0[NET_Y] ^ gold_p0[NET_Y];
    end
  end
`endif

endmodule

// File: tb/tb_fault_injection_module.sv
// Testbench for fault_injection_module.
// It applies directed vectors from a table and adds short hand-written multi-cycle sequences.
module tb_fault_injection_module;

  logic       clk = 1'b0;
  logic       rst_n, a, b, e, f, fault_en;
  logic [2:0] fault_site;
  logic [1:0] fault_type;
  logic       y;
`ifdef INJ_GOLDEN_OUT_EN
  logic       y_golden, mismatch;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fault_injection_module #(.RESET_Y(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .e          (e),
    .f          (f),
    .fault_en   (fault_en),
    .fault_site (fault_site),
    .fault_type (fault_type),
`ifdef INJ_GOLDEN_OUT_EN
    .y_golden   (y_golden),
    .mismatch   (mismatch),
`endif
    .y          (y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       a, b, e, f;
    logic       en;
    logic [2:0] site;
    logic [1:0] ftype;
    logic       exp_y;
    logic       exp_g;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic va, input logic vb, input logic ve,
                              input logic vf, input logic en, input logic [2:0] site,
                              input logic [1:0] ft, input logic ey, input logic eg);
    vec_t v;
    v.rst_n = r; v.a = va; v.b = vb; v.e = ve; v.f = vf;
    v.en = en; v.site = site; v.ftype = ft; v.exp_y = ey; v.exp_g = eg;
    return v;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive on the falling edge and sample 1 time unit after the next rising edge.
  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    rst_n = v.rst_n; a = v.a; b = v.b; e = v.e; f = v.f;
    fault_en = v.en; fault_site = v.site; fault_type = v.ftype;
    @(posedge clk);
    #1;
    check({name, ".y"}, y, v.exp_y);
`ifdef INJ_GOLDEN_OUT_EN
    check({name, ".golden"}, y_golden, v.exp_g);
    check({name, ".mismatch"}, mismatch, v.exp_y ^ v.exp_g);
`endif
  endtask

  initial begin
    rst_n = 1'b0; a = 0; b = 0; e = 0; f = 0;
    fault_en = 0; fault_site = 3'd7; fault_type = 2'd0;

    //             r  a  b  e  f  en site  type   y  g
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 3'd7, 2'd0, 0, 0)); // reset state
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 3'd7, 2'd0, 1, 1)); // fault-free e&~f
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 3'd7, 2'd0, 0, 0)); // fault-free all off
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 3'd4, 2'd0, 0, 1)); // SA0 on n1
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 3'd3, 2'd1, 0, 0)); // SA1 on f
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 3'd3, 2'd0, 1, 0)); // SA0 on f
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 3'd7, 2'd0, 0, 0)); // a=0 setup
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, 3'd0, 2'd2, 0, 1)); // STR a rising
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, 3'd0, 2'd2, 1, 1)); // STR a settled
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 3'd6, 2'd3, 1, 1)); // STF y held high
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'd6, 2'd3, 1, 0)); // STF y falling
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3'd6, 2'd3, 0, 0)); // STF y settled
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 3'd7, 2'd0, 1, 1)); // y=1 before reset
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 3'd6, 2'd1, 0, 0)); // reset dominates SA1
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 3'd4, 2'd2, 0, 1)); // STR n1 just after reset
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 3'd7, 2'd0, 1, 1)); // site 7 means golden
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3'd5, 2'd1, 1, 0)); // SA1 on n2
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 3'd2, 2'd0, 0, 1)); // SA0 on e
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 3'd1, 2'd1, 1, 0)); // SA1 on b

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // STF on n1: the 1->0 edge holds for one cycle and then clears.
    step(mk(1, 1, 1, 0, 0, 0, 3'd7, 2'd0, 1, 1), "stf_n1.setup");
    step(mk(1, 0, 1, 0, 0, 1, 3'd4, 2'd3, 1, 0), "stf_n1.fall");
    step(mk(1, 0, 1, 0, 0, 1, 3'd4, 2'd3, 0, 0), "stf_n1.settle");

    // Reset held for two cycles while SA1 is active on y.
    step(mk(0, 0, 0, 0, 0, 1, 3'd6, 2'd1, 0, 0), "rst_hold.c0");
    step(mk(0, 1, 1, 1, 0, 1, 3'd6, 2'd1, 0, 0), "rst_hold.c1");
    step(mk(1, 0, 0, 0, 0, 1, 3'd6, 2'd1, 1, 0), "rst_hold.release");

    // STR on input e just after reset: the first 1 counts as rising.
    step(mk(0, 0, 0, 0, 0, 0, 3'd7, 2'd0, 0, 0), "str_e.reset");
    step(mk(1, 0, 0, 1, 0, 1, 3'd2, 2'd2, 0, 1), "str_e.rise");
    step(mk(1, 0, 0, 1, 0, 1, 3'd2, 2'd2, 1, 1), "str_e.settle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
